// File: rtl/riscv_wb_pkg.sv
// rtl/riscv_wb_pkg.sv - shared encodings for the writeback stage
package riscv_wb_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_PC4  = 2'd2,
    WB_IMM  = 2'd3
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - load byte/half/word selection, extension and alignment check
module load_extend
  import riscv_wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] word,
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  output logic [XLEN-1:0] data,
  output logic            err
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_v = word[7:0];
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      default: byte_v = word[31:24];
    endcase
    half_v = addr_lo[1] ? word[31:16] : word[15:0];

    data = '0;
    err  = 1'b0;
    case (funct3)
      F3_LB:   data = {{(XLEN-8){byte_v[7]}}, byte_v};
      F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_v};
      F3_LH: begin
        err  = addr_lo[0];
        data = {{(XLEN-16){half_v[15]}}, half_v};
      end
      F3_LHU: begin
        err  = addr_lo[0];
        data = {{(XLEN-16){1'b0}}, half_v};
      end
      F3_LW: begin
        err  = (addr_lo != 2'd0);
        data = word;
      end
      default: err = 1'b1;
    endcase
    // a faulting load never leaks partial data into the register file
    if (err) data = '0;
  end

endmodule

// File: rtl/reg_writeback.sv
// rtl/reg_writeback.sv - WB stage: result select, regfile write port, RAW scoreboard (WB_RETIRE_CNT_EN adds retire counter)
module reg_writeback
  import riscv_wb_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int RETIRE_W = 64,
  localparam int RW      = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m_valid,
  output logic                m_ready,
  input  logic                hold,
  input  logic                m_wr,
  input  logic [RW-1:0]       m_rd,
  input  logic [1:0]          m_wb_sel,
  input  logic [XLEN-1:0]     m_alu_res,
  input  logic [XLEN-1:0]     m_imm,
  input  logic [XLEN-1:0]     m_pc,
  input  logic [XLEN-1:0]     m_load_word,
  input  logic [2:0]          m_funct3,
  input  logic [1:0]          m_addr_lo,
  input  logic                iss_valid,
  input  logic [RW-1:0]       iss_rd,
  input  logic [RW-1:0]       q_rs1,
  input  logic [RW-1:0]       q_rs2,
  output logic                busy1,
  output logic                busy2,
  output logic                w_en,
  output logic [RW-1:0]       rd,
  output logic [XLEN-1:0]     wdata,
  output logic                load_err,
  output logic [RETIRE_W-1:0] retire_cnt
);

  logic            accept;
  logic [XLEN-1:0] ext_data;
  logic            ext_err;
  logic            lerr;
  logic [XLEN-1:0] res;
  logic [NREG-1:0] sb;
  logic [NREG-1:0] set_vec;
  logic [NREG-1:0] clr_vec;
  logic [NREG-1:0] sb_next;

  assign m_ready = ~hold;
  assign accept  = m_valid & ~hold;

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .word    (m_load_word),
    .funct3  (m_funct3),
    .addr_lo (m_addr_lo),
    .data    (ext_data),
    .err     (ext_err)
  );

  assign lerr = (m_wb_sel == WB_LOAD) & ext_err;

  always_comb begin
    case (m_wb_sel)
      WB_ALU:  res = m_alu_res;
      WB_LOAD: res = ext_data;
      WB_PC4:  res = m_pc + XLEN'(4);
      default: res = m_imm;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_en     <= 1'b0;
      rd       <= '0;
      wdata    <= '0;
      load_err <= 1'b0;
    end else begin
      w_en     <= accept & m_wr & (m_rd != '0) & ~lerr;
      load_err <= accept & lerr;
      if (accept) begin
        rd    <= m_rd;
        wdata <= lerr ? '0 : res;
      end
    end
  end

  // Set is applied after clear so a newer issuer of the same rd keeps it pending.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (iss_valid && (iss_rd != '0)) set_vec[iss_rd] = 1'b1;
    if (accept && m_wr)              clr_vec[m_rd]   = 1'b1;
    sb_next    = (sb & ~clr_vec) | set_vec;
    sb_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sb <= '0;
    else      sb <= sb_next;
  end

  assign busy1 = (q_rs1 != '0) & sb[q_rs1] & ~(clr_vec[q_rs1] & ~set_vec[q_rs1]);
  assign busy2 = (q_rs2 != '0) & sb[q_rs2] & ~(clr_vec[q_rs2] & ~set_vec[q_rs2]);

`ifdef WB_RETIRE_CNT_EN
  logic [RETIRE_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        cnt <= '0;
    else if (accept) cnt <= cnt + {{(RETIRE_W-1){1'b0}}, 1'b1};
  end

  assign retire_cnt = cnt;
`else
  assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// tb/tb_reg_writeback.sv - directed and randomized check of reg_writeback against a reference model
module tb_reg_writeback;
  import riscv_wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_valid, m_ready, hold, m_wr;
  logic [4:0]  m_rd;
  logic [1:0]  m_wb_sel;
  logic [31:0] m_alu_res, m_imm, m_pc, m_load_word;
  logic [2:0]  m_funct3;
  logic [1:0]  m_addr_lo;
  logic        iss_valid;
  logic [4:0]  iss_rd, q_rs1, q_rs2;
  logic        busy1, busy2, w_en, load_err;
  logic [4:0]  rd;
  logic [31:0] wdata;
  logic [63:0] retire_cnt;

  int checks = 0;
  int failures = 0;

  bit                sb_m [32];
  bit                e_wen, e_lerr;
  logic [4:0]        e_rd;
  logic [31:0]       e_wdata;
  longint unsigned   e_ret;

  always #5 clk = ~clk;

  reg_writeback dut (
    .clk(clk), .rst(rst), .m_valid(m_valid), .m_ready(m_ready), .hold(hold),
    .m_wr(m_wr), .m_rd(m_rd), .m_wb_sel(m_wb_sel), .m_alu_res(m_alu_res),
    .m_imm(m_imm), .m_pc(m_pc), .m_load_word(m_load_word), .m_funct3(m_funct3),
    .m_addr_lo(m_addr_lo), .iss_valid(iss_valid), .iss_rd(iss_rd),
    .q_rs1(q_rs1), .q_rs2(q_rs2), .busy1(busy1), .busy2(busy2), .w_en(w_en),
    .rd(rd), .wdata(wdata), .load_err(load_err), .retire_cnt(retire_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [2:0] f3,
                                           input logic [1:0] a, output bit err);
    int unsigned b, h;
    b   = (word >> (8 * a)) & 32'hFF;
    h   = (word >> (16 * (a / 2))) & 32'hFFFF;
    err = 1'b0;
    case (f3)
      3'd0: return (b >= 128) ? b - 256 : b;
      3'd4: return b;
      3'd1: begin err = a[0]; return err ? 32'd0 : ((h >= 32768) ? h - 65536 : h); end
      3'd5: begin err = a[0]; return err ? 32'd0 : h; end
      3'd2: begin err = (a != 0); return err ? 32'd0 : word; end
      default: begin err = 1'b1; return 32'd0; end
    endcase
  endfunction

  function automatic bit exp_busy(input logic [4:0] q, input bit acc);
    if (q == 0) return 1'b0;
    if (iss_valid && iss_rd == q) return sb_m[q];
    if (acc && m_wr && m_rd == q) return 1'b0;
    return sb_m[q];
  endfunction

  task automatic reset_model();
    foreach (sb_m[i]) sb_m[i] = 1'b0;
    e_wen = 0; e_lerr = 0; e_rd = 0; e_wdata = 0; e_ret = 0;
  endtask

  task automatic set_idle();
    m_valid = 0; hold = 0; m_wr = 0; m_rd = 0; m_wb_sel = WB_ALU;
    m_alu_res = 0; m_imm = 0; m_pc = 0; m_load_word = 0; m_funct3 = 0; m_addr_lo = 0;
    iss_valid = 0; iss_rd = 0; q_rs1 = 0; q_rs2 = 0;
  endtask

  task automatic prep_load(input logic [31:0] word, input logic [2:0] f3,
                           input logic [1:0] a, input logic [4:0] r);
    m_valid = 1; m_wr = 1; m_rd = r; m_wb_sel = WB_LOAD;
    m_load_word = word; m_funct3 = f3; m_addr_lo = a;
  endtask

  // One clock: check combinational outputs, advance the model, check registered outputs.
  task automatic tick();
    bit acc, err;
    logic [31:0] res;
    #1;
    acc = m_valid && !hold;
    err = 1'b0;
    chk("m_ready", m_ready, !hold);
    chk("busy1", busy1, exp_busy(q_rs1, acc));
    chk("busy2", busy2, exp_busy(q_rs2, acc));
    if (acc) begin
      case (m_wb_sel)
        2'd0:    res = m_alu_res;
        2'd1:    res = ref_load(m_load_word, m_funct3, m_addr_lo, err);
        2'd2:    res = m_pc + 32'd4;
        default: res = m_imm;
      endcase
      e_wen   = m_wr && (m_rd != 0) && !err;
      e_rd    = m_rd;
      e_wdata = err ? 32'd0 : res;
      e_lerr  = err;
      e_ret++;
      if (m_wr) sb_m[m_rd] = 1'b0;
    end else begin
      e_wen  = 0;
      e_lerr = 0;
    end
    if (iss_valid && iss_rd != 0) sb_m[iss_rd] = 1'b1;
    @(posedge clk);
    #1;
    chk("w_en", w_en, e_wen);
    chk("rd", rd, e_rd);
    chk("wdata", wdata, e_wdata);
    chk("load_err", load_err, e_lerr);
`ifdef WB_RETIRE_CNT_EN
    chk("retire_cnt", retire_cnt, e_ret);
`else
    chk("retire_cnt", retire_cnt, 64'd0);
`endif
  endtask

  initial begin
    rst = 1'b0;
    set_idle();
    reset_model();
    #2;
    chk("rst_w_en", w_en, 0);
    chk("rst_rd", rd, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_load_err", load_err, 0);
    chk("rst_retire", retire_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // ALU writeback then idle
    m_valid = 1; m_wr = 1; m_rd = 5; m_alu_res = 32'h1234_5678;
    tick();
    chk("alu_w_en", w_en, 1);
    chk("alu_rd", rd, 5);
    chk("alu_wdata", wdata, 32'h1234_5678);
    set_idle(); tick();
    chk("idle_w_en", w_en, 0);
    chk("idle_wdata_hold", wdata, 32'h1234_5678);

    // load extension
    set_idle(); prep_load(32'h80FF_7F01, F3_LB, 2'd1, 5'd3); tick();
    chk("lb_a1", wdata, 32'h0000_007F);
    set_idle(); prep_load(32'h80FF_7F01, F3_LB, 2'd3, 5'd3); tick();
    chk("lb_a3", wdata, 32'hFFFF_FF80);
    set_idle(); prep_load(32'h80FF_7F01, F3_LBU, 2'd2, 5'd3); tick();
    chk("lbu_a2", wdata, 32'h0000_00FF);
    set_idle(); prep_load(32'h80FF_7F01, F3_LH, 2'd2, 5'd3); tick();
    chk("lh_a2", wdata, 32'hFFFF_80FF);
    set_idle(); prep_load(32'h80FF_7F01, F3_LW, 2'd0, 5'd3); tick();
    chk("lw_a0", wdata, 32'h80FF_7F01);

    // misaligned LH still clears its scoreboard entry
    set_idle(); iss_valid = 1; iss_rd = 10; tick();
    set_idle(); q_rs1 = 10; #1;
    chk("sb10_set", busy1, 1);
    prep_load(32'h80FF_7F01, F3_LH, 2'd1, 5'd10); #1;
    chk("sb10_clearing", busy1, 0);
    tick();
    chk("lh_mis_err", load_err, 1);
    chk("lh_mis_wen", w_en, 0);
    chk("lh_mis_wdata", wdata, 0);
    set_idle(); q_rs1 = 10; tick();
    chk("lh_mis_pulse", load_err, 0);
    chk("sb10_clear", busy1, 0);
    set_idle(); prep_load(32'h1, 3'b011, 2'd0, 5'd4); tick();
    chk("f3_011_err", load_err, 1);

    // x0 and PC+4 wrap
    set_idle(); m_valid = 1; m_wr = 1; m_rd = 0; m_alu_res = 32'hDEAD_BEEF; tick();
    chk("x0_w_en", w_en, 0);
    set_idle(); m_valid = 1; m_wr = 1; m_rd = 1; m_wb_sel = WB_PC4; m_pc = 32'hFFFF_FFFC; tick();
    chk("jal_wdata", wdata, 0);
    chk("jal_w_en", w_en, 1);

    // scoreboard set-wins and accept-only clear
    set_idle(); iss_valid = 1; iss_rd = 7; tick();
    set_idle(); q_rs1 = 7; #1;
    chk("sb7_busy", busy1, 1);
    m_valid = 1; m_wr = 1; m_rd = 7; iss_valid = 1; iss_rd = 7; #1;
    chk("sb7_set_wins", busy1, 1);
    tick();
    set_idle(); q_rs1 = 7; #1;
    chk("sb7_still", busy1, 1);
    m_valid = 1; m_wr = 1; m_rd = 7; #1;
    chk("sb7_clear_now", busy1, 0);
    tick();
    set_idle(); q_rs1 = 7; #1;
    chk("sb7_cleared", busy1, 0);

    // hold
    hold = 1; m_valid = 1; m_wr = 1; m_rd = 12; m_alu_res = 32'h55; iss_valid = 1; iss_rd = 12; #1;
    chk("hold_ready", m_ready, 0);
    tick();
    chk("hold_w_en", w_en, 0);
    chk("hold_rd", rd, 7);
    set_idle(); q_rs2 = 12; #1;
    chk("hold_sb_set", busy2, 1);

    // asynchronous reset with a result in flight
    m_valid = 1; m_wr = 1; m_rd = 9; m_alu_res = 32'hAAAA_AAAA; iss_valid = 1; iss_rd = 3; #1;
    rst = 1'b0; #1;
    reset_model();
    chk("mrst_w_en", w_en, 0);
    chk("mrst_rd", rd, 0);
    chk("mrst_busy2", busy2, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    set_idle(); q_rs1 = 3; q_rs2 = 12; tick();
    chk("mrst_no_write", w_en, 0);
    chk("mrst_wdata", wdata, 0);

    // randomized traffic over a small register window to provoke hazards
    for (int n = 0; n < 400; n++) begin
      m_valid     = ($urandom_range(0, 3) != 0);
      hold        = ($urandom_range(0, 6) == 0);
      m_wr        = ($urandom_range(0, 4) != 0);
      m_rd        = 5'($urandom_range(0, 7));
      m_wb_sel    = 2'($urandom_range(0, 3));
      m_alu_res   = $urandom;
      m_imm       = $urandom;
      m_pc        = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : $urandom;
      m_load_word = $urandom;
      m_funct3    = 3'($urandom_range(0, 7));
      m_addr_lo   = 2'($urandom_range(0, 3));
      iss_valid   = ($urandom_range(0, 1) == 1);
      iss_rd      = ($urandom_range(0, 3) == 0) ? m_rd : 5'($urandom_range(0, 7));
      q_rs1       = ($urandom_range(0, 2) == 0) ? m_rd : 5'($urandom_range(0, 7));
      q_rs2       = 5'($urandom_range(0, 7));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
